// File: rtl/soi_obs_pkg.sv
// SysObs SOI export types shared by the sample arbiter and the DPI bridge.
package soi_obs_pkg;

  typedef enum logic {
    IDLE,
    PRESENT
  } soi_arb_state_e;

  function automatic int soi_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SOI_NUM_REQ = 4;
  localparam int SOI_DATA_W  = 1;
  localparam int SOI_TS_W    = 32;
  localparam int SOI_ID_W    = soi_id_w(SOI_NUM_REQ);

  typedef struct packed {
    logic [SOI_ID_W-1:0]   id;
    logic [SOI_DATA_W-1:0] data;
    logic [SOI_TS_W-1:0]   ts;
  } soi_sample_t;

endpackage

// File: rtl/soi_sample_arbiter_if.sv
// Probe-side and bridge-side handshakes of the SOI sample arbiter.
interface soi_sample_arbiter_if
  import soi_obs_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SOI_W   = 1,
  parameter int TS_W    = 32
);
  localparam int ID_W = soi_id_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*SOI_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [ID_W-1:0]          out_id;
  logic [SOI_W-1:0]         out_data;
  logic [TS_W-1:0]          out_ts;
  logic                     busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_id,
    input  out_data, out_ts, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_id,
    output out_data, out_ts, busy
  );
endinterface

// File: rtl/soi_rr_arbiter.sv
// Combinational round-robin pick; search starts one past the last grant.
module soi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = ID_W'((int'(last) + i) % NUM_REQ);
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/soi_sample_arbiter.sv
// Round-robin share of the DPI SOI export channel among probe points,
// tagging each captured sample with probe ID and capture timestamp.
module soi_sample_arbiter
  import soi_obs_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SOI_W   = 1,
  parameter int TS_W    = 32
) (
  input logic clk,
  input logic rst,
  soi_sample_arbiter_if.slave bus
);

  localparam int ID_W = soi_id_w(NUM_REQ);

  soi_arb_state_e state_q;
  soi_arb_state_e state_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               capture;

  logic [ID_W-1:0]  last_q;
  logic [TS_W-1:0]  ts_q;
  logic [ID_W-1:0]  id_q;
  logic [SOI_W-1:0] data_q;
  logic [TS_W-1:0]  cap_ts_q;

  soi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req  (bus.req_valid),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          bus.req_ready = gnt;
          if (gnt_any) begin
            capture = 1'b1;
            state_d = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  // pointer resets to the top index so probe 0 wins the first pick
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= ID_W'(NUM_REQ - 1);
      ts_q     <= '0;
      id_q     <= '0;
      data_q   <= '0;
      cap_ts_q <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + TS_W'(1);
      if (capture) begin
        last_q   <= gnt_idx;
        id_q     <= gnt_idx;
        data_q   <= bus.req_data[gnt_idx*SOI_W +: SOI_W];
        cap_ts_q <= ts_q;
      end
    end
  end

  assign bus.out_valid = (state_q == PRESENT);
  assign bus.busy      = (state_q == PRESENT);
  assign bus.out_id    = id_q;
  assign bus.out_data  = data_q;
  assign bus.out_ts    = cap_ts_q;

endmodule

// File: tb/tb_soi_sample_arbiter.sv
// Scoreboard bench for soi_sample_arbiter with a 4-bit timestamp.
module tb_soi_sample_arbiter;

  localparam int N  = 4;
  localparam int SW = 1;
  localparam int TW = 4;

  typedef struct {
    logic [1:0] id;
    logic       d;
    logic [3:0] ts;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soi_sample_arbiter_if #(.NUM_REQ(N), .SOI_W(SW), .TS_W(TW)) bus ();

  soi_sample_arbiter #(
    .NUM_REQ (N),
    .SOI_W   (SW),
    .TS_W    (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic [3:0] model_ts;
  logic [3:0] cap;
  logic [3:0] dv;

  always @(posedge clk) model_ts <= rst ? 4'd0 : model_ts + 4'd1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push(logic [1:0] id, logic d, logic [3:0] ts);
    exp_t e;
    e.id = id;
    e.d  = d;
    e.ts = ts;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", 32'(bus.out_id), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_id", 32'(bus.out_id), 32'(e.id));
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("out_ts", 32'(bus.out_ts), 32'(e.ts));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_ts", 32'(bus.out_ts), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      tick();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    tick();

    // single probe 2
    tick();
    bus.req_valid = 4'b0100;
    bus.req_data  = 4'b0100;
    push(2'd2, 1'b1, model_ts);
    @(negedge clk);
    chk("single_grant", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_busy", 32'(bus.busy), 1);
    chk("single_no_grant", 32'(bus.req_ready), 0);
    tick();
    @(negedge clk);
    chk("single_drop", 32'(bus.out_valid), 0);

    // timestamp wrap: capture at 15, next capture at 1
    guard = 0;
    tick();
    while (model_ts != 4'd15 && guard < 40) begin
      tick();
      guard++;
    end
    chk("ts_wait", 32'(guard < 40), 1);
    bus.req_valid = 4'b0001;
    bus.req_data  = 4'b0001;
    push(2'd0, 1'b1, 4'd15);
    @(negedge clk);
    chk("wrap_grant0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    bus.req_valid = 4'b0010;
    bus.req_data  = 4'b0010;
    push(2'd1, 1'b1, 4'd1);
    @(negedge clk);
    chk("wrap_grant1", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = '0;
    tick();

    // backpressure on probe 3 with probe 0 waiting
    tick();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1000;
    bus.req_data  = 4'b1001;
    cap = model_ts;
    push(2'd3, 1'b1, cap);
    @(negedge clk);
    chk("bp_grant", 32'(bus.req_ready), 32'b1000);
    tick();
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_busy", 32'(bus.busy), 1);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_id", 32'(bus.out_id), 3);
      chk("bp_data", 32'(bus.out_data), 1);
      chk("bp_ts", 32'(bus.out_ts), 32'(cap));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    push(2'd0, 1'b1, model_ts);
    @(negedge clk);
    chk("bp_next_grant", 32'(bus.req_ready), 32'b0001);
    chk("bp_single_accept", 32'(bus.out_valid), 0);
    tick();
    bus.req_valid = '0;
    tick();

    // reset while presenting discards the sample
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_data  = 4'b0000;
    tick();
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_presenting", 32'(bus.out_valid), 1);
    tick();
    @(negedge clk);
    chk("mid_valid", 32'(bus.out_valid), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_id", 32'(bus.out_id), 0);
    chk("mid_ts", 32'(bus.out_ts), 0);
    chk("mid_req_ready", 32'(bus.req_ready), 0);
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;

    // round robin, all probes valid, starting from probe 0
    dv = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      tick();
      bus.req_valid = 4'b1111;
      bus.req_data  = dv;
      push(2'(k % 4), dv[k % 4], model_ts);
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      tick();
      @(negedge clk);
      chk("rr_busy", 32'(bus.busy), 1);
      chk("rr_hold", 32'(bus.req_ready), 0);
    end
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
